pipe_mux_reg: RTL

//   Parametrised N:1 datapath select stage with registered output and a 2-entry skid buffer.

---
 rtl/pipe_mux_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N:1 select stage with registered output and 2-entry skid buffer.
// Optional PIPE_MUX_SEL_ERR_EN: discard out-of-range beats and flag them on sel_err.
module pipe_mux_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    CLOCK,
  input  logic                    CLEAR_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic [CNT_W-1:0]        beat_cnt
`ifdef PIPE_MUX_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   beat_data;
  logic               accept, emit, take;

  // Out-of-range selects match no lane and fall through to zero.
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) beat_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign accept = in_valid & in_ready_q;
  assign emit   = (state_q != S_EMPTY) & out_ready;

`ifdef PIPE_MUX_SEL_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
  logic sel_ok;
  logic sel_err_q;
  assign sel_ok  = ({1'b0, in_sel} < NUM_IN_W);
  assign take    = accept & sel_ok;
  assign sel_err = sel_err_q;

  always_ff @(posedge CLOCK) begin
    if (!CLEAR_N) sel_err_q <= 1'b0;
    else          sel_err_q <= accept & ~sel_ok;
  end
`else
  assign take = accept;
`endif

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    cnt_d       = cnt_q;
    if (take) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      S_EMPTY: begin
        if (take) begin
          state_d     = S_ONE;
          main_data_d = beat_data;
          main_sel_d  = in_sel;
        end
      end
      S_ONE: begin
        if (take && emit) begin
          main_data_d = beat_data;
          main_sel_d  = in_sel;
        end else if (take) begin
          state_d     = S_TWO;
          skid_data_d = beat_data;
          skid_sel_d  = in_sel;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (emit) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Registered ready: derived from the next state, never from out_ready directly.
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR_N) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign beat_cnt  = cnt_q;

endmodule
